// File: rtl/capture_pkg.sv
// Shared types and constants for the capture sequencer: FSM states, channel
// count, packed-word field positions and checksum width.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned CKSUM_W = 24;

  // Field index within the packed RAM word; va occupies the MSBs.
  localparam int unsigned FLD_VA = 5;
  localparam int unsigned FLD_VB = 4;
  localparam int unsigned FLD_VC = 3;
  localparam int unsigned FLD_IA = 2;
  localparam int unsigned FLD_IB = 1;
  localparam int unsigned FLD_IC = 0;

  function automatic int unsigned field_lsb(input int unsigned fld, input int unsigned data_w);
    return fld * data_w;
  endfunction

endpackage

// File: rtl/capture_sequencer_edge_rise.sv
// Registered rising-edge detector: rise = din & ~din_prev.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_prev;

  always_ff @(posedge clk) begin
    if (reset) din_prev <= 1'b0;
    else       din_prev <= din;
  end

  assign rise = din & ~din_prev;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one six-channel ADC acquisition into the sample RAM with a Nios
// finish/ack handshake. Optional running checksum: define CAPTURE_CHECKSUM_EN.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DECIM  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       take_sample,
  input  logic                       cs_frame,
  input  logic [DATA_W-1:0]          va_in,
  input  logic [DATA_W-1:0]          vb_in,
  input  logic [DATA_W-1:0]          vc_in,
  input  logic [DATA_W-1:0]          ia_in,
  input  logic [DATA_W-1:0]          ib_in,
  input  logic [DATA_W-1:0]          ic_in,
  input  logic                       read_ack,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [NUM_CH*DATA_W-1:0]   wr_data,
  output logic                       busy,
  output logic                       writing_finish_flag,
  output logic [ADDR_W:0]            frames_written
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [CKSUM_W-1:0]         checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        LAST_DECIM = 8'(DECIM - 1);

  state_t state, state_next;
  logic   trig_rise, cs_rise, ack_rise;
  logic   capture_hit, do_write;
  logic [7:0] decim_cnt, decim_base;
  logic [NUM_CH*DATA_W-1:0] frame_word;

  edge_rise u_trig (.clk(clk), .reset(reset), .din(take_sample), .rise(trig_rise));
  edge_rise u_cs   (.clk(clk), .reset(reset), .din(cs_frame),    .rise(cs_rise));
  edge_rise u_ack  (.clk(clk), .reset(reset), .din(read_ack),    .rise(ack_rise));

  always_comb begin
    frame_word = '0;
    frame_word[field_lsb(FLD_VA, DATA_W) +: DATA_W] = va_in;
    frame_word[field_lsb(FLD_VB, DATA_W) +: DATA_W] = vb_in;
    frame_word[field_lsb(FLD_VC, DATA_W) +: DATA_W] = vc_in;
    frame_word[field_lsb(FLD_IA, DATA_W) +: DATA_W] = ia_in;
    frame_word[field_lsb(FLD_IB, DATA_W) +: DATA_W] = ib_in;
    frame_word[field_lsb(FLD_IC, DATA_W) +: DATA_W] = ic_in;
  end

  // The arming edge is the first candidate frame, so it sees a counter of 0.
  always_comb begin
    capture_hit = cs_rise && (state == ARM || state == CAPTURE);
    decim_base  = (state == ARM) ? '0 : decim_cnt;
    do_write    = capture_hit && (decim_base == '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig_rise) state_next = ARM;
      ARM:     if (cs_rise) state_next = CAPTURE;
      CAPTURE: if (wr_en && wr_addr == LAST_ADDR) state_next = DONE;
      DONE:    if (ack_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frames_written <= '0;
      decim_cnt      <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) wr_data <= frame_word;
      if (capture_hit) decim_cnt <= (decim_base == LAST_DECIM) ? '0 : decim_base + 8'd1;
      if (state == IDLE && trig_rise) begin
        wr_addr        <= '0;
        frames_written <= '0;
      end
      // Address advances after the strobe so wr_addr is stable during wr_en.
      if (wr_en) begin
        wr_addr        <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        frames_written <= frames_written + 1'b1;
      end
    end
  end

  assign busy                = (state == ARM) || (state == CAPTURE);
  assign writing_finish_flag = (state == DONE);

`ifdef CAPTURE_CHECKSUM_EN
  logic [CKSUM_W-1:0] word_sum;

  always_comb begin
    word_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      word_sum = word_sum + CKSUM_W'(wr_data[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk) begin
    if (reset)                           checksum <= '0;
    else if (state == IDLE && trig_rise) checksum <= '0;
    else if (wr_en)                      checksum <= checksum + word_sum;
  end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: two instances (DEPTH=8/DECIM=1 and
// DEPTH=4/DECIM=3) share one stimulus stream. Honors CAPTURE_CHECKSUM_EN.
module tb_capture_sequencer;

  logic        clk, reset, take_sample, cs_frame, read_ack;
  logic [7:0]  va, vb, vc, ia, ib, ic;

  logic        wr_en_a, busy_a, flag_a, wr_en_b, busy_b, flag_b;
  logic [11:0] wr_addr_a, wr_addr_b;
  logic [47:0] wr_data_a, wr_data_b;
  logic [12:0] frames_a, frames_b;
`ifdef CAPTURE_CHECKSUM_EN
  logic [23:0] cksum_a, cksum_b;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned stray  = 0;

  logic [11:0] qa_addr[$], qb_addr[$];
  logic [47:0] qa_data[$], qb_data[$];

  capture_sequencer #(.DEPTH(8), .ADDR_W(12), .DATA_W(8), .DECIM(1)) u_a (
    .clk(clk), .reset(reset), .take_sample(take_sample), .cs_frame(cs_frame),
    .va_in(va), .vb_in(vb), .vc_in(vc), .ia_in(ia), .ib_in(ib), .ic_in(ic),
    .read_ack(read_ack), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .writing_finish_flag(flag_a), .frames_written(frames_a)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(cksum_a)
`endif
  );

  capture_sequencer #(.DEPTH(4), .ADDR_W(12), .DATA_W(8), .DECIM(3)) u_b (
    .clk(clk), .reset(reset), .take_sample(take_sample), .cs_frame(cs_frame),
    .va_in(va), .vb_in(vb), .vc_in(vc), .ia_in(ia), .ib_in(ib), .ic_in(ic),
    .read_ack(read_ack), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .writing_finish_flag(flag_b), .frames_written(frames_b)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(cksum_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_a) begin
      qa_addr.push_back(wr_addr_a);
      qa_data.push_back(wr_data_a);
      if (!busy_a) stray++;
    end
    if (wr_en_b) begin
      qb_addr.push_back(wr_addr_b);
      qb_data.push_back(wr_data_b);
      if (!busy_b) stray++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_data(input logic [7:0] v);
    va = v;
    vb = 8'(v + 8'h10);
    vc = 8'(v + 8'h20);
    ia = 8'(v + 8'h30);
    ib = 8'(v + 8'h40);
    ic = 8'(v + 8'h50);
  endtask

  task automatic frame(input logic [7:0] v);
    set_data(v);
    cs_frame = 1'b1;
    tick();
    tick();
    cs_frame = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [47:0] exp_word(input logic [7:0] v);
    return {v, 8'(v + 8'h10), 8'(v + 8'h20), 8'(v + 8'h30), 8'(v + 8'h40), 8'(v + 8'h50)};
  endfunction

  task automatic clear_queues();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
  endtask

  initial begin
    reset = 1'b1; take_sample = 1'b0; cs_frame = 1'b0; read_ack = 1'b0;
    set_data(8'h00);
    tick();
    tick();
    check("reset_a", {wr_en_a, wr_addr_a, wr_data_a, busy_a, flag_a}, '0);
    check("reset_frames_a", frames_a, 0);
    check("reset_b", {wr_en_b, wr_addr_b, wr_data_b, busy_b, flag_b, frames_b}, '0);
    reset = 1'b0;
    tick();

    frame(8'h55);
    check("idle_no_write", qa_addr.size() + qb_addr.size(), 0);

    take_sample = 1'b1;
    tick();
    check("arm_busy_a", busy_a, 1);
    check("arm_busy_b", busy_b, 1);
    check("arm_no_wr", wr_en_a, 0);

    for (int k = 0; k < 12; k++) begin
      frame(8'(8'h10 + k));
      if (k == 3) begin
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        tick();
        check("ack_in_capture_busy", busy_a, 1);
        check("ack_in_capture_flag", flag_a, 0);
      end
    end

    check("a_done_flag", flag_a, 1);
    check("a_done_busy", busy_a, 0);
    check("a_frames", frames_a, 8);
    check("a_addr_wrap", wr_addr_a, 0);
    check("a_nwrites", qa_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < qa_addr.size()) begin
        check("a_addr", qa_addr[i], i);
        check("a_data", qa_data[i], exp_word(8'(8'h10 + i)));
      end
    end
    check("b_done_flag", flag_b, 1);
    check("b_frames", frames_b, 4);
    check("b_nwrites", qb_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < qb_addr.size()) begin
        check("b_addr", qb_addr[i], i);
        check("b_data", qb_data[i], exp_word(8'(8'h10 + 3 * i)));
      end
    end
`ifdef CAPTURE_CHECKSUM_EN
    begin
      logic [23:0] ea, eb;
      ea = '0;
      eb = '0;
      for (int k = 0; k < 8; k++) ea = ea + 24'(6 * (16 + k) + 240);
      for (int k = 0; k < 12; k += 3) eb = eb + 24'(6 * (16 + k) + 240);
      check("a_checksum", cksum_a, ea);
      check("b_checksum", cksum_b, eb);
    end
`endif

    take_sample = 1'b0;
    tick();
    take_sample = 1'b1;
    tick();
    check("trig_in_done_flag", flag_a, 1);
    check("trig_in_done_busy", busy_a, 0);
    take_sample = 1'b0;
    tick();

    take_sample = 1'b1;
    read_ack = 1'b1;
    tick();
    check("ack_wins_flag_a", flag_a, 0);
    check("ack_wins_flag_b", flag_b, 0);
    check("ack_wins_busy_a", busy_a, 0);
    tick();
    check("trig_dropped", busy_a, 0);
    check("frames_hold", frames_a, 8);
    take_sample = 1'b0;
    read_ack = 1'b0;
    tick();

    clear_queues();
    set_data(8'h77);
    take_sample = 1'b1;
    cs_frame = 1'b1;
    tick();
    check("collide_arm", busy_a, 1);
    check("collide_no_wr0", wr_en_a, 0);
    tick();
    check("collide_no_wr1", wr_en_a, 0);
    cs_frame = 1'b0;
    tick();
    tick();
    check("collide_nwrites", qa_addr.size() + qb_addr.size(), 0);
    frame(8'hA0);
    check("first_after_collide_n", qa_addr.size(), 1);
    if (qa_addr.size() > 0) begin
      check("first_after_collide_addr", qa_addr[0], 0);
      check("first_after_collide_data", qa_data[0], exp_word(8'hA0));
    end
    if (qb_addr.size() > 0) check("b_first_after_collide", qb_data[0], exp_word(8'hA0));
    frame(8'hA1);
    check("frames_before_third", frames_a, 2);

    set_data(8'hA2);
    cs_frame = 1'b1;
    tick();
    check("third_wr_en", wr_en_a, 1);
    check("third_addr", wr_addr_a, 2);
    reset = 1'b1;
    take_sample = 1'b0;
    cs_frame = 1'b0;
    tick();
    check("midreset_a", {wr_en_a, wr_addr_a, wr_data_a, busy_a, flag_a}, '0);
    check("midreset_frames_a", frames_a, 0);
    check("midreset_b", {wr_en_b, wr_addr_b, wr_data_b, busy_b, flag_b, frames_b}, '0);
`ifdef CAPTURE_CHECKSUM_EN
    check("midreset_cksum", cksum_a, 0);
`endif
    reset = 1'b0;
    tick();
    frame(8'hC0);
    check("after_reset_qa", qa_addr.size(), 3);
    check("after_reset_qb", qb_addr.size(), 1);

    clear_queues();
    take_sample = 1'b1;
    tick();
    frame(8'hB0);
    check("restart_n", qa_addr.size(), 1);
    if (qa_addr.size() > 0) begin
      check("restart_addr", qa_addr[0], 0);
      check("restart_data", qa_data[0], exp_word(8'hB0));
    end
    if (qb_addr.size() > 0) check("restart_addr_b", qb_addr[0], 0);
    check("restart_frames", frames_a, 1);
    check("no_stray_wr_en", stray, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
